// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle LEGv8 sequencer and its datapath.
// The master side is the sequencer: it reads the IR opcode, ALU zero flag and
// memory handshake, and drives every datapath control plus status/debug.
interface multicycle_control_if #(
    parameter int CNT_W = 32
);
    logic [10:0]      opcode;
    logic             zero;
    logic             mem_ready;
    logic             PCWrite;
    logic             PCWriteCond;
    logic             PCSrc;
    logic             IorD;
    logic             IRWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             MemtoReg;
    logic             RegWrite;
    logic             Reg2Loc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOp;
    logic             instr_done;
    logic             illegal;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state;

    modport master (
        input  opcode, zero, mem_ready,
        output PCWrite, PCWriteCond, PCSrc, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
               instr_done, illegal, retired, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  PCWrite, PCWriteCond, PCSrc, IorD, IRWrite, MemRead, MemWrite,
               MemtoReg, RegWrite, Reg2Loc, ALUSrcA, ALUSrcB, ALUOp,
               instr_done, illegal, retired, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencer: steps R-type, LDUR, STUR and CBZ through
// fetch/decode/execute/memory/writeback, waiting on the memory handshake,
// and counts retired instructions. Pure state decodes are registered (loaded
// from the next state); only the handshake- and opcode-dependent strobes are
// combinational from the current state.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_LD   = 4'd6,
        WB_LD    = 4'd7,
        MEM_ST   = 4'd8,
        BR       = 4'd9
    } state_t;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_src;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       memto_reg;
        logic       reg_write;
        logic       reg2loc;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       done;
    } moore_t;

    // Opcode classes shared with the single-cycle decoder.
    function automatic logic is_rtype(input logic [10:0] op);
        return op[10] && (op[7:4] == 4'b0101) && (op[2:0] == 3'b000);
    endfunction

    // LDUR (..10) and STUR (..00); the ..01/..11 variants are not loads/stores.
    function automatic logic is_dtype(input logic [10:0] op);
        return (op[10:3] == 8'b11111000) && !op[0];
    endfunction

    function automatic logic is_cbz(input logic [10:0] op);
        return op[10:3] == 8'b10110100;
    endfunction

    function automatic state_t next_state(input state_t s, input logic [10:0] op,
                                          input logic mr);
        state_t n;
        n = s;
        case (s)
            IDLE:     n = FETCH;
            FETCH:    n = mr ? DECODE : FETCH;
            DECODE: begin
                if (is_rtype(op))      n = EXEC_R;
                else if (is_dtype(op)) n = MEM_ADDR;
                else if (is_cbz(op))   n = BR;
                else                   n = FETCH;
            end
            EXEC_R:   n = WB_R;
            WB_R:     n = FETCH;
            MEM_ADDR: n = op[1] ? MEM_LD : MEM_ST;
            MEM_LD:   n = mr ? WB_LD : MEM_LD;
            WB_LD:    n = FETCH;
            MEM_ST:   n = mr ? FETCH : MEM_ST;
            BR:       n = FETCH;
            default:  n = IDLE;
        endcase
        return n;
    endfunction

    // Controls that depend on nothing but the state they are asserted in.
    function automatic moore_t moore(input state_t s);
        moore_t m;
        m = '0;
        case (s)
            FETCH: begin
                m.mem_read  = 1'b1;
                m.alu_src_b = 2'b01;
            end
            DECODE:   m.alu_src_b = 2'b11;
            EXEC_R: begin
                m.alu_src_a = 1'b1;
                m.alu_op    = 2'b10;
            end
            WB_R: begin
                m.reg_write = 1'b1;
                m.done      = 1'b1;
            end
            MEM_ADDR: begin
                m.alu_src_a = 1'b1;
                m.alu_src_b = 2'b10;
                m.reg2loc   = 1'b1;
            end
            MEM_LD: begin
                m.mem_read = 1'b1;
                m.iord     = 1'b1;
            end
            WB_LD: begin
                m.reg_write = 1'b1;
                m.memto_reg = 1'b1;
                m.done      = 1'b1;
            end
            MEM_ST: begin
                m.mem_write = 1'b1;
                m.iord      = 1'b1;
                m.reg2loc   = 1'b1;
            end
            BR: begin
                m.alu_src_a     = 1'b1;
                m.alu_op        = 2'b01;
                m.reg2loc       = 1'b1;
                m.pc_write_cond = 1'b1;
                m.pc_src        = 1'b1;
                m.done          = 1'b1;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    state_t           state_reg;
    moore_t           ctrl_reg;
    logic [CNT_W-1:0] retired_reg;

    logic in_decode;
    logic fetch_go;
    logic store_go;
    logic instr_done;

    assign in_decode  = (state_reg == DECODE);
    assign fetch_go   = (state_reg == FETCH) && bus.mem_ready;
    assign store_go   = (state_reg == MEM_ST) && bus.mem_ready;
    assign instr_done = ctrl_reg.done || store_go;

    // State, registered Moore controls and the retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ctrl_reg    <= '0;
            retired_reg <= '0;
        end else begin
            state_reg <= next_state(state_reg, bus.opcode, bus.mem_ready);
            ctrl_reg  <= moore(next_state(state_reg, bus.opcode, bus.mem_ready));
            if (instr_done) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    assign bus.PCWrite     = fetch_go;
    assign bus.IRWrite     = fetch_go;
    assign bus.PCWriteCond = ctrl_reg.pc_write_cond;
    assign bus.PCSrc       = ctrl_reg.pc_src;
    assign bus.IorD        = ctrl_reg.iord;
    assign bus.MemRead     = ctrl_reg.mem_read;
    assign bus.MemWrite    = ctrl_reg.mem_write;
    assign bus.MemtoReg    = ctrl_reg.memto_reg;
    assign bus.RegWrite    = ctrl_reg.reg_write;
    assign bus.Reg2Loc     = ctrl_reg.reg2loc ||
                             (in_decode && (is_dtype(bus.opcode) || is_cbz(bus.opcode)));
    assign bus.ALUSrcA     = ctrl_reg.alu_src_a;
    assign bus.ALUSrcB     = ctrl_reg.alu_src_b;
    assign bus.ALUOp       = ctrl_reg.alu_op;
    assign bus.instr_done  = instr_done;
    assign bus.illegal     = in_decode && !(is_rtype(bus.opcode) || is_dtype(bus.opcode) ||
                                            is_cbz(bus.opcode));
    assign bus.retired     = retired_reg;
    assign bus.state       = state_reg;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into its expected
// per-cycle sequence of (state, control word, retired) from the instruction
// class and the memory wait pattern; a compare process checks every cycle.
module tb_multicycle_control;
    localparam int W = 4;   // small counter so wrap-around is reachable

    localparam int K_R = 0, K_LD = 1, K_ST = 2, K_CBZ = 3, K_ILL = 4;

    // control word bit masks
    localparam logic [16:0] PCW  = 17'h10000;
    localparam logic [16:0] PCWC = 17'h08000;
    localparam logic [16:0] PCS  = 17'h04000;
    localparam logic [16:0] IORD = 17'h02000;
    localparam logic [16:0] IRW  = 17'h01000;
    localparam logic [16:0] MR   = 17'h00800;
    localparam logic [16:0] MW   = 17'h00400;
    localparam logic [16:0] M2R  = 17'h00200;
    localparam logic [16:0] RW   = 17'h00100;
    localparam logic [16:0] R2L  = 17'h00080;
    localparam logic [16:0] ASA  = 17'h00040;
    localparam logic [16:0] DONE = 17'h00002;
    localparam logic [16:0] ILL  = 17'h00001;

    function automatic logic [16:0] asb(input logic [1:0] v);
        return {11'b0, v, 4'b0};
    endfunction
    function automatic logic [16:0] aop(input logic [1:0] v);
        return {13'b0, v, 2'b0};
    endfunction

    typedef struct {
        logic [3:0]   st;
        logic [16:0]  cw;
        logic [W-1:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ncyc = 0;
    logic [W-1:0] model_cnt = '0;
    exp_t q[$];

    multicycle_control_if #(.CNT_W(W)) m ();

    multicycle_control #(.CNT_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] act_cw();
        return {m.PCWrite, m.PCWriteCond, m.PCSrc, m.IorD, m.IRWrite, m.MemRead,
                m.MemWrite, m.MemtoReg, m.RegWrite, m.Reg2Loc, m.ALUSrcA,
                m.ALUSrcB, m.ALUOp, m.instr_done, m.illegal};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the expectation queue.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", 32'(m.state), 32'(e.st));
            chk("ctrl", 32'(act_cw()), 32'(e.cw));
            chk("retired", 32'(m.retired), 32'(e.ret));
        end
    end

    // Push one cycle's expectation without advancing the clock.
    task automatic push(input logic mr, input logic [10:0] op, input logic z,
                        input logic [3:0] st, input logic [16:0] cw);
        exp_t e;
        m.mem_ready = mr;
        m.opcode    = op;
        m.zero      = z;
        e.st  = st;
        e.cw  = cw;
        e.ret = model_cnt;
        q.push_back(e);
        if ((cw & DONE) != 17'h0) model_cnt = model_cnt + 1'b1;
        ncyc++;
    endtask

    task automatic cycle(input logic mr, input logic [10:0] op, input logic z,
                         input logic [3:0] st, input logic [16:0] cw);
        push(mr, op, z, st, cw);
        @(posedge clk);
        #1;
    endtask

    // Expected cycle sequence of a whole instruction.
    task automatic run_instr(input int kind, input logic [10:0] op, input int fw,
                             input int mw, input logic z, input logic ign);
        int c0;
        logic [16:0] dec;
        c0 = ncyc;
        for (int i = 0; i < fw; i++) cycle(1'b0, op, z, 4'd1, MR | asb(2'b01));
        cycle(1'b1, op, z, 4'd1, PCW | IRW | MR | asb(2'b01));
        dec = asb(2'b11);
        if (kind == K_LD || kind == K_ST || kind == K_CBZ) dec = dec | R2L;
        if (kind == K_ILL) dec = dec | ILL;
        cycle(ign, op, z, 4'd2, dec);
        case (kind)
            K_R: begin
                cycle(ign, op, z, 4'd3, ASA | aop(2'b10));
                cycle(ign, op, z, 4'd4, RW | DONE);
            end
            K_LD: begin
                cycle(ign, op, z, 4'd5, ASA | asb(2'b10) | R2L);
                for (int i = 0; i < mw; i++) cycle(1'b0, op, z, 4'd6, MR | IORD);
                cycle(1'b1, op, z, 4'd6, MR | IORD);
                cycle(ign, op, z, 4'd7, RW | M2R | DONE);
            end
            K_ST: begin
                cycle(ign, op, z, 4'd5, ASA | asb(2'b10) | R2L);
                for (int i = 0; i < mw; i++) cycle(1'b0, op, z, 4'd8, MW | IORD | R2L);
                cycle(1'b1, op, z, 4'd8, MW | IORD | R2L | DONE);
            end
            K_CBZ: cycle(ign, op, z, 4'd9, ASA | aop(2'b01) | R2L | PCWC | PCS | DONE);
            default: ;
        endcase
        $display("instr kind=%0d op=%b cycles=%0d retired=%0d", kind, op, ncyc - c0, m.retired);
    endtask

    logic [10:0] ops [4];
    int c_start;

    initial begin
        ops[0] = 11'b10001011000;   // ADD
        ops[1] = 11'b11001011000;   // SUB
        ops[2] = 11'b10001010000;   // AND
        ops[3] = 11'b10101010000;   // ORR
        m.mem_ready = 1'b1;
        m.opcode    = '0;
        m.zero      = 1'b0;

        // reset: everything quiet
        #12;
        chk("rst_state", 32'(m.state), 32'd0);
        chk("rst_ctrl", 32'(act_cw()), 32'd0);
        chk("rst_retired", 32'(m.retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 11'b0, 1'b0, 4'd0, 17'h0);

        c_start = ncyc;
        run_instr(K_R, 11'b10001011000, 0, 0, 1'b0, 1'b1);
        chk("add_cycles", 32'(ncyc - c_start), 32'd4);
        @(negedge clk);
        chk("add_retired", 32'(m.retired), 32'd1);
        @(posedge clk);
        #1;
        // the extra cycle above sat in FETCH with mem_ready=1: account for it
        // by restarting cleanly through a reset below is unnecessary; instead
        // keep the model aligned: that cycle fetched nothing new (opcode ADD)
        // so continue from the DECODE of a second ADD.
        cycle(1'b1, 11'b10001011000, 1'b0, 4'd2, asb(2'b11));
        cycle(1'b1, 11'b10001011000, 1'b0, 4'd3, ASA | aop(2'b10));
        cycle(1'b1, 11'b10001011000, 1'b0, 4'd4, RW | DONE);

        c_start = ncyc;
        run_instr(K_LD, 11'b11111000010, 0, 2, 1'b0, 1'b0);
        chk("ldur_cycles", 32'(ncyc - c_start), 32'd7);
        chk("ldur_retired", 32'(m.retired), 32'd3);
        run_instr(K_ST, 11'b11111000000, 1, 1, 1'b0, 1'b1);
        run_instr(K_CBZ, 11'b10110100101, 0, 0, 1'b1, 1'b0);
        run_instr(K_CBZ, 11'b10110100011, 0, 0, 1'b0, 1'b1);
        chk("cbz_retired", 32'(m.retired), 32'd6);
        run_instr(K_ILL, 11'b00000000000, 0, 0, 1'b0, 1'b0);
        chk("ill_retired", 32'(m.retired), 32'd6);
        run_instr(K_ILL, 11'b11111000001, 0, 0, 1'b0, 1'b1);
        run_instr(K_ILL, 11'b11111000011, 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            case (i % 4)
                0: run_instr(K_R, ops[i % 4 == 0 ? (i / 4) % 4 : 0], 0, 0, 1'b0, 1'(i % 2));
                1: run_instr(K_LD, 11'b11111000010, i % 2, 1, 1'b0, 1'(i % 2));
                2: run_instr(K_ST, 11'b11111000000, 0, i % 3, 1'b0, 1'b0);
                default: run_instr(K_R, ops[3], 1, 0, 1'b0, 1'b1);
            endcase
        end
        // 6 + 11 = 17 retirements, 4-bit counter wraps to 1
        chk("wrap_retired", 32'(m.retired), 32'd1);

        // reset in the middle of a load that is waiting on memory
        run_instr(K_R, ops[1], 0, 0, 1'b0, 1'b1);
        push(1'b1, 11'b11111000010, 1'b0, 4'd1, PCW | IRW | MR | asb(2'b01));
        @(posedge clk); #1;
        cycle(1'b0, 11'b11111000010, 1'b0, 4'd2, asb(2'b11) | R2L);
        cycle(1'b0, 11'b11111000010, 1'b0, 4'd5, ASA | asb(2'b10) | R2L);
        push(1'b0, 11'b11111000010, 1'b0, 4'd6, MR | IORD);
        @(negedge clk);
        #2;
        chk("mid_memread_before", 32'(m.MemRead), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_memread", 32'(m.MemRead), 32'd0);
        chk("mid_state", 32'(m.state), 32'd0);
        chk("mid_retired", 32'(m.retired), 32'd0);
        m.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_hold_state", 32'(m.state), 32'd0);
        chk("mid_hold_ctrl", 32'(act_cw()), 32'd0);
        rst_n = 1'b1;
        model_cnt = '0;
        cycle(1'b1, 11'b0, 1'b0, 4'd0, 17'h0);
        run_instr(K_R, ops[2], 0, 0, 1'b0, 1'b0);
        chk("post_rst_retired", 32'(m.retired), 32'd1);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
